// File: rtl/seq_match_monitor.sv
// seq_match_monitor: turns the 1011 detector's detect output into rising-edge
// events. It counts events per threshold window and raises a level interrupt
// that is held until acknowledged. It also keeps a saturating total count and
// tracks the last and minimum gap between events.
module seq_match_monitor #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             match_in,
  input  logic [CNT_W-1:0] threshold,
  input  logic             clear,
  input  logic             irq_ack,
  output logic             irq,
  output logic             overrun,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] total_count,
  output logic [GAP_W-1:0] last_gap,
  output logic [GAP_W-1:0] min_gap,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ALERT = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0] GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

  state_t           state_reg;
  logic             irq_reg;
  logic             overrun_reg;
  logic [CNT_W-1:0] match_count_reg;
  logic [CNT_W-1:0] total_count_reg;
  logic [GAP_W-1:0] last_gap_reg;
  logic [GAP_W-1:0] min_gap_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [CNT_W-1:0] thr_q_reg;
  logic             match_d_reg;
  logic             first_seen_reg;

  logic             ev;
  logic             active;
  logic [CNT_W-1:0] thr_eff;
  logic [CNT_W-1:0] match_count_next;
  logic [GAP_W-1:0] gap_next;

  // A detect that stays high for several cycles produces only one event.
  assign ev               = match_in & ~match_d_reg & enable;
  // Statistics are only collected while a window is open.
  assign active           = (state_reg == COUNT) || (state_reg == ALERT);
  // A threshold of zero would never fire, so it behaves as one.
  assign thr_eff          = (threshold == '0) ? CNT_ONE : threshold;
  assign match_count_next = match_count_reg + CNT_ONE;
  // The gap counter saturates. The same saturated value is the gap reported on an event.
  assign gap_next         = (gap_cnt_reg == '1) ? gap_cnt_reg : gap_cnt_reg + GAP_ONE;

  // Window FSM with its registered outputs (irq, overrun, match_count) and the latched threshold.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      irq_reg         <= 1'b0;
      overrun_reg     <= 1'b0;
      match_count_reg <= '0;
      thr_q_reg       <= CNT_ONE;
    end else if (clear) begin
      state_reg       <= enable ? COUNT : IDLE;
      irq_reg         <= 1'b0;
      overrun_reg     <= 1'b0;
      match_count_reg <= '0;
      thr_q_reg       <= thr_eff;
    end else if (!enable) begin
      state_reg       <= IDLE;
      irq_reg         <= 1'b0;
      overrun_reg     <= 1'b0;
      match_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          state_reg <= COUNT;
          thr_q_reg <= thr_eff;
        end
        COUNT: begin
          if (ev) begin
            match_count_reg <= match_count_next;
            if (match_count_next == thr_q_reg) begin
              state_reg <= ALERT;
              irq_reg   <= 1'b1;
            end
          end
        end
        ALERT: begin
          if (irq_ack) begin
            overrun_reg <= 1'b0;
            if (ev) begin
              // The event that arrives with the ack opens the new window.
              match_count_reg <= CNT_ONE;
              if (thr_q_reg == CNT_ONE) begin
                state_reg <= ALERT;
                irq_reg   <= 1'b1;
              end else begin
                state_reg <= COUNT;
                irq_reg   <= 1'b0;
              end
            end else begin
              match_count_reg <= '0;
              state_reg       <= COUNT;
              irq_reg         <= 1'b0;
            end
          end else if (ev) begin
            overrun_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Edge-detect history, saturating total count and inter-event gap statistics.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      match_d_reg     <= 1'b0;
      total_count_reg <= '0;
      last_gap_reg    <= '0;
      min_gap_reg     <= '1;
      gap_cnt_reg     <= '0;
      first_seen_reg  <= 1'b0;
    end else begin
      match_d_reg <= match_in;
      if (clear) begin
        total_count_reg <= '0;
        last_gap_reg    <= '0;
        min_gap_reg     <= '1;
        gap_cnt_reg     <= '0;
        first_seen_reg  <= 1'b0;
      end else if (!active) begin
        gap_cnt_reg    <= '0;
        first_seen_reg <= 1'b0;
      end else if (ev) begin
        if (total_count_reg != '1) begin
          total_count_reg <= total_count_reg + CNT_ONE;
        end
        gap_cnt_reg <= '0;
        if (first_seen_reg) begin
          last_gap_reg <= gap_next;
          if (gap_next < min_gap_reg) begin
            min_gap_reg <= gap_next;
          end
        end else begin
          first_seen_reg <= 1'b1;
        end
      end else begin
        gap_cnt_reg <= gap_next;
      end
    end
  end

  assign irq         = irq_reg;
  assign overrun     = overrun_reg;
  assign match_count = match_count_reg;
  assign total_count = total_count_reg;
  assign last_gap    = last_gap_reg;
  assign min_gap     = min_gap_reg;
  assign state_o     = state_reg;

endmodule
